// File: rtl/dot_matrix_rx.sv
// Receiver for a serial dot-matrix driver: synchronizes the shift/latch pins,
// rebuilds the column and row chains, and latches one display line per LE rise.
module dot_matrix_rx #(
  parameter int NCOLS = 32,
  parameter int NROWS = 8,
  localparam int CW  = $clog2(NCOLS + 2),
  localparam int RIW = (NROWS > 1) ? $clog2(NROWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CCLK,
  input  logic             CSDI,
  input  logic             RCLK,
  input  logic             RSDI,
  input  logic             LE,
  input  logic             OEB,
  output logic [NCOLS-1:0] cols,
  output logic [NROWS-1:0] rows,
  output logic [RIW-1:0]   row_idx,
  output logic             line_valid,
  output logic             row_err,
  output logic             len_err,
  output logic             display_on
);

  // Pin order in the synchronizer vectors: {OEB, LE, RSDI, RCLK, CSDI, CCLK}
  logic [5:0]       pin_s1_q, pin_s1_d, pin_s2_q, pin_s2_d;
  logic [2:0]       edge_q, edge_d;   // {LE, RCLK, CCLK} delayed copies
  logic [NCOLS-1:0] col_shift_q, col_shift_d, cols_q, cols_d;
  logic [NROWS-1:0] row_shift_q, row_shift_d, rows_q, rows_d;
  logic [CW-1:0]    col_cnt_q, col_cnt_d;
  logic [RIW-1:0]   row_idx_q, row_idx_d, low_idx;
  logic             line_valid_q, line_valid_d;
  logic             row_err_q, row_err_d, len_err_q, len_err_d;
  logic             display_on_q, display_on_d;
  logic             c_rise, r_rise, l_rise;

  always_comb begin
    pin_s1_d = {OEB, LE, RSDI, RCLK, CSDI, CCLK};
    pin_s2_d = pin_s1_q;
    edge_d   = {pin_s2_q[4], pin_s2_q[2], pin_s2_q[0]};
    c_rise   = pin_s2_q[0] & ~edge_q[0];
    r_rise   = pin_s2_q[2] & ~edge_q[1];
    l_rise   = pin_s2_q[4] & ~edge_q[2];

    col_shift_d = col_shift_q;
    col_cnt_d   = col_cnt_q;
    row_shift_d = row_shift_q;
    if (c_rise) begin
      col_shift_d = {col_shift_q[NCOLS-2:0], pin_s2_q[1]};
      if (col_cnt_q != CW'(NCOLS + 1)) col_cnt_d = col_cnt_q + 1'b1;
    end
    if (r_rise) row_shift_d = {row_shift_q[NROWS-2:0], pin_s2_q[3]};

    low_idx = '0;
    for (int i = NROWS - 1; i >= 0; i--)
      if (row_shift_d[i]) low_idx = RIW'(i);

    cols_d       = cols_q;
    rows_d       = rows_q;
    row_idx_d    = row_idx_q;
    line_valid_d = 1'b0;
    row_err_d    = row_err_q;
    len_err_d    = len_err_q;
    // A coincident shift edge is already folded into the *_d chains and count.
    if (l_rise) begin
      cols_d       = col_shift_d;
      rows_d       = row_shift_d;
      row_idx_d    = low_idx;
      line_valid_d = 1'b1;
      if (col_cnt_d != CW'(NCOLS)) len_err_d = 1'b1;
      if ($countones(row_shift_d) != 1) row_err_d = 1'b1;
      col_cnt_d    = '0;
    end

    // Registering ~stage1 matches ~OEB_sync timing and stays 0 in reset.
    display_on_d = ~pin_s1_q[5];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_s1_q     <= '0;
      pin_s2_q     <= '0;
      edge_q       <= '0;
      col_shift_q  <= '0;
      row_shift_q  <= '0;
      col_cnt_q    <= '0;
      cols_q       <= '0;
      rows_q       <= '0;
      row_idx_q    <= '0;
      line_valid_q <= 1'b0;
      row_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      display_on_q <= 1'b0;
    end else begin
      pin_s1_q     <= pin_s1_d;
      pin_s2_q     <= pin_s2_d;
      edge_q       <= edge_d;
      col_shift_q  <= col_shift_d;
      row_shift_q  <= row_shift_d;
      col_cnt_q    <= col_cnt_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      row_idx_q    <= row_idx_d;
      line_valid_q <= line_valid_d;
      row_err_q    <= row_err_d;
      len_err_q    <= len_err_d;
      display_on_q <= display_on_d;
    end
  end

  assign cols       = cols_q;
  assign rows       = rows_q;
  assign row_idx    = row_idx_q;
  assign line_valid = line_valid_q;
  assign row_err    = row_err_q;
  assign len_err    = len_err_q;
  assign display_on = display_on_q;

endmodule

// File: tb/tb_dot_matrix_rx.sv
// Bench for dot_matrix_rx: directed line scenarios plus random pin activity,
// all checked every cycle against a pin-history model of the receiver.
module tb_dot_matrix_rx;
  localparam int NCOLS = 32;
  localparam int NROWS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic CCLK = 0, CSDI = 0, RCLK = 0, RSDI = 0, LE = 0, OEB = 1;
  logic [NCOLS-1:0] cols;
  logic [NROWS-1:0] rows;
  logic [2:0]       row_idx;
  logic line_valid, row_err, len_err, display_on;

  int checks = 0, failures = 0, lv_cnt = 0;

  dot_matrix_rx #(.NCOLS(NCOLS), .NROWS(NROWS)) dut (
    .clk(clk), .reset(reset), .CCLK(CCLK), .CSDI(CSDI), .RCLK(RCLK),
    .RSDI(RSDI), .LE(LE), .OEB(OEB), .cols(cols), .rows(rows),
    .row_idx(row_idx), .line_valid(line_valid), .row_err(row_err),
    .len_err(len_err), .display_on(display_on)
  );

  always #5 clk = ~clk;

  // Model: a pin value sampled at edge t is acted on at edge t+2 (edge seen
  // when the two-edges-old sample is 1 and the three-edges-old sample is 0).
  logic [5:0]  p1, p2, p3, cur;  // pin samples 1,2,3 edges ago: {OEB,LE,RSDI,RCLK,CSDI,CCLK}
  logic [31:0] m_cshift, m_cols;
  logic [7:0]  m_rshift, m_rows;
  logic [2:0]  m_idx;
  logic        m_lv, m_rerr, m_lerr, m_disp;
  int          m_cnt;

  initial begin
    logic [45:0] act, exp;
    p1 = 0; p2 = 0; p3 = 0;
    m_cshift = 0; m_cols = 0; m_rshift = 0; m_rows = 0; m_idx = 0;
    m_lv = 0; m_rerr = 0; m_lerr = 0; m_disp = 0; m_cnt = 0;
    forever begin
      @(posedge clk);
      cur = {OEB, LE, RSDI, RCLK, CSDI, CCLK};
      #1;
      if (reset) begin
        p1 = 0; p2 = 0; p3 = 0;
        m_cshift = 0; m_cols = 0; m_rshift = 0; m_rows = 0; m_idx = 0;
        m_lv = 0; m_rerr = 0; m_lerr = 0; m_disp = 0; m_cnt = 0;
      end else begin
        m_lv   = 0;
        m_disp = ~p1[5];
        if (p2[0] && !p3[0]) begin
          m_cshift = (m_cshift << 1) | 32'(p2[1]);
          if (m_cnt < NCOLS + 1) m_cnt++;
        end
        if (p2[2] && !p3[2]) m_rshift = (m_rshift << 1) | 8'(p2[3]);
        if (p2[4] && !p3[4]) begin
          m_cols = m_cshift;
          m_rows = m_rshift;
          m_idx  = 0;
          for (int i = NROWS - 1; i >= 0; i--) if (m_rshift[i]) m_idx = 3'(i);
          m_lv = 1;
          if (m_cnt != NCOLS) m_lerr = 1;
          if ($countones(m_rshift) != 1) m_rerr = 1;
          m_cnt = 0;
        end
        p3 = p2; p2 = p1; p1 = cur;
      end
      act = {cols, rows, row_idx, line_valid, row_err, len_err, display_on};
      exp = {m_cols, m_rows, m_idx, m_lv, m_rerr, m_lerr, m_disp};
      checks++;
      if (act !== exp) begin
        failures++;
        if (failures <= 20)
          $display("FAIL cycle_model t=%0t got cols=%h rows=%h idx=%0d lv=%b rerr=%b lerr=%b disp=%b want cols=%h rows=%h idx=%0d lv=%b rerr=%b lerr=%b disp=%b",
                   $time, cols, rows, row_idx, line_valid, row_err, len_err, display_on,
                   m_cols, m_rows, m_idx, m_lv, m_rerr, m_lerr, m_disp);
      end
      if (line_valid) lv_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic col_bit(input logic b);
    CSDI = b; CCLK = 0; tick(2); CCLK = 1; tick(2); CCLK = 0;
  endtask

  task automatic row_bit(input logic b);
    RSDI = b; RCLK = 0; tick(2); RCLK = 1; tick(2); RCLK = 0;
  endtask

  task automatic latch();
    LE = 1; tick(2); LE = 0; tick(4);
  endtask

  task automatic send_line(input logic [31:0] cw, input int nbits, input logic [7:0] rw);
    for (int i = nbits - 1; i >= 0; i--) col_bit(cw[i]);
    for (int i = 7; i >= 0; i--) row_bit(rw[i]);
    latch();
  endtask

  task automatic do_reset(input int n);
    reset = 1; tick(n); reset = 0; tick(1);
  endtask

  initial begin
    int lv0;
    tick(3);
    chk("reset_outputs", {cols[15:0], rows, 3'(row_idx), line_valid, row_err, len_err, display_on}, 0);
    reset = 0; tick(2);

    // Known line
    lv0 = lv_cnt;
    send_line(32'hDEADBEEF, 32, 8'h04);
    chk("l1_cols", cols, 32'hDEADBEEF);
    chk("l1_rows", rows, 8'h04);
    chk("l1_idx", row_idx, 2);
    chk("l1_pulses", lv_cnt - lv0, 1);
    chk("l1_errs", {row_err, len_err}, 0);
    chk("model_cols_pin", m_cols, 32'hDEADBEEF);

    // Short line then correct line
    send_line(32'h0000_1234, 31, 8'h01);
    chk("short_len_err", len_err, 1);
    send_line(32'h12345678, 32, 8'h01);
    chk("after_short_cols", cols, 32'h12345678);
    chk("len_err_sticky", len_err, 1);
    chk("model_lerr_pin", m_lerr, 1);

    // Row one-hot errors
    do_reset(2);
    send_line(32'hA5A5A5A5, 32, 8'h00);
    chk("rows0_err", row_err, 1);
    chk("rows0_idx", row_idx, 0);
    send_line(32'hA5A5A5A5, 32, 8'h11);
    chk("rows11_idx", row_idx, 0);
    chk("rows11_err", row_err, 1);
    chk("rows11_rows", rows, 8'h11);

    // Coincident 32nd CCLK rise and LE rise
    do_reset(2);
    for (int i = 31; i >= 1; i--) col_bit(1'(32'hDEADBEEF >> i));
    for (int i = 7; i >= 0; i--) row_bit(i == 3);
    CSDI = 1; CCLK = 0; tick(2);
    CCLK = 1; LE = 1; tick(2); CCLK = 0; LE = 0; tick(4);
    chk("coinc_cols", cols, 32'hDEADBEEF);
    chk("coinc_bit0", cols[0], 1);
    chk("coinc_len_err", len_err, 0);

    // Reset mid-shift discards partial data
    for (int i = 0; i < 10; i++) col_bit(1'(i & 1));
    reset = 1; tick(2);
    chk("midreset_outputs", {cols[15:0], rows, 3'(row_idx), line_valid, row_err, len_err, display_on}, 0);
    reset = 0; tick(1);
    send_line(32'hCAFEF00D, 32, 8'h80);
    chk("postreset_cols", cols, 32'hCAFEF00D);
    chk("postreset_len", len_err, 0);
    chk("postreset_idx", row_idx, 7);

    // OEB low -> display_on exactly two edges later
    OEB = 0;
    @(posedge clk); #1 chk("oeb_edge1", display_on, 0);
    @(posedge clk); #1 chk("oeb_edge2", display_on, 1);
    tick(1);
    // LE rise -> line_valid exactly three edges later
    LE = 1;
    @(posedge clk); #1 chk("le_edge1", line_valid, 0);
    @(posedge clk); #1 chk("le_edge2", line_valid, 0);
    @(posedge clk); #1 chk("le_edge3", line_valid, 1);
    tick(1); LE = 0; tick(4);

    // LE held high through reset release
    LE = 1; reset = 1; tick(2); reset = 0;
    @(posedge clk); #1 chk("hold_edge1", line_valid, 0);
    @(posedge clk); #1 chk("hold_edge2", line_valid, 0);
    @(posedge clk); #1 chk("hold_edge3", line_valid, 1);
    tick(1); LE = 0; tick(4);

    // Random pin activity, checked only by the cycle model
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 3) == 0) CCLK = ~CCLK;
      if ($urandom_range(0, 1) == 0) CSDI = 1'($urandom);
      if ($urandom_range(0, 3) == 0) RCLK = ~RCLK;
      if ($urandom_range(0, 1) == 0) RSDI = 1'($urandom);
      if ($urandom_range(0, 40) == 0) LE = ~LE;
      if ($urandom_range(0, 20) == 0) OEB = ~OEB;
      reset = ($urandom_range(0, 700) == 0);
      tick(1);
    end
    reset = 0; tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
